// File: rtl/level_monitor.sv
// Filtered level measurement for a thermometer-coded probe column, with
// programmable high/low thresholds and hysteresis alarming.
module level_monitor #(
    parameter int N_SENSORS      = 8,
    parameter int LEVEL_W        = $clog2(N_SENSORS + 1),
    parameter int STABLE_SAMPLES = 4,
    parameter int ERR_SAMPLES    = 3,
    parameter int HYST           = 1
) (
    input  logic                 clk_100MHz,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic [N_SENSORS-1:0] sensors_input,
    input  logic [LEVEL_W-1:0]   setup_input,
    input  logic                 save_high,
    input  logic                 save_low,
    output logic [LEVEL_W-1:0]   level,
    output logic                 level_valid,
    output logic                 input_error,
    output logic [LEVEL_W-1:0]   high_threshold,
    output logic [LEVEL_W-1:0]   low_threshold,
    output logic                 prog_error,
    output logic                 GOET,
    output logic                 LOET,
    output logic [2:0]           alarm_state
);
    localparam int SC_W = $clog2(STABLE_SAMPLES + 1);
    localparam int EC_W = $clog2(ERR_SAMPLES + 1);
    localparam int CW   = LEVEL_W + 1;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_NORMAL = 3'd1,
        ST_HIGH   = 3'd2,
        ST_LOW    = 3'd3,
        ST_FAULT  = 3'd4
    } alarm_t;

    // Reset asserts immediately but releases on a clock edge.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    logic [N_SENSORS-1:0] sens_meta;
    logic [N_SENSORS-1:0] sens_sync;

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            sens_meta <= '0;
            sens_sync <= '0;
        end else begin
            sens_meta <= sensors_input;
            sens_sync <= sens_meta;
        end
    end

    // A legal column reads 0..01..1: adding one must clear every set bit.
    logic [N_SENSORS-1:0] sens_plus1;
    logic                 sample_ok;
    logic [LEVEL_W-1:0]   sample_lvl;

    assign sens_plus1 = sens_sync + 1'b1;
    assign sample_ok  = (sens_sync & sens_plus1) == '0;

    always_comb begin
        sample_lvl = '0;
        for (int i = 0; i < N_SENSORS; i++)
            sample_lvl = sample_lvl + LEVEL_W'(sens_sync[i]);
    end

    logic [LEVEL_W-1:0] candidate;
    logic [SC_W-1:0]    stable_cnt;
    logic [SC_W-1:0]    stable_nxt;
    logic [EC_W-1:0]    err_cnt;
    logic [EC_W-1:0]    err_nxt;

    always_comb begin
        if (sample_lvl != candidate)
            stable_nxt = SC_W'(1);
        else if (stable_cnt == SC_W'(STABLE_SAMPLES))
            stable_nxt = stable_cnt;
        else
            stable_nxt = stable_cnt + 1'b1;
        if (err_cnt == EC_W'(ERR_SAMPLES))
            err_nxt = err_cnt;
        else
            err_nxt = err_cnt + 1'b1;
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            candidate   <= '0;
            stable_cnt  <= '0;
            err_cnt     <= '0;
            level       <= '0;
            level_valid <= 1'b0;
            input_error <= 1'b0;
        end else if (sample_tick) begin
            if (sample_ok) begin
                candidate  <= sample_lvl;
                stable_cnt <= stable_nxt;
                err_cnt    <= '0;
                if (stable_nxt == SC_W'(STABLE_SAMPLES)) begin
                    level       <= sample_lvl;
                    level_valid <= 1'b1;
                    input_error <= 1'b0;
                end
            end else begin
                stable_cnt <= '0;
                err_cnt    <= err_nxt;
                if (err_nxt == EC_W'(ERR_SAMPLES))
                    input_error <= 1'b1;
            end
        end
    end

    // Simultaneous requests: the high write wins and the low write is reported as dropped.
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            high_threshold <= LEVEL_W'(N_SENSORS);
            low_threshold  <= '0;
            prog_error     <= 1'b0;
        end else begin
            prog_error <= 1'b0;
            if (save_high) begin
                if (setup_input > low_threshold && CW'(setup_input) <= CW'(N_SENSORS))
                    high_threshold <= setup_input;
                else
                    prog_error <= 1'b1;
                if (save_low)
                    prog_error <= 1'b1;
            end else if (save_low) begin
                if (setup_input < high_threshold)
                    low_threshold <= setup_input;
                else
                    prog_error <= 1'b1;
            end
        end
    end

    logic [CW-1:0] lvl_x;
    logic [CW-1:0] hi_x;
    logic [CW-1:0] lo_x;
    alarm_t        alarm_q;
    alarm_t        alarm_nxt;

    assign lvl_x = CW'(level);
    assign hi_x  = CW'(high_threshold);
    assign lo_x  = CW'(low_threshold);

    always_comb begin
        alarm_nxt = alarm_q;
        if (input_error) begin
            alarm_nxt = ST_FAULT;
        end else begin
            case (alarm_q)
                ST_INIT:   if (level_valid) alarm_nxt = ST_NORMAL;
                ST_NORMAL: begin
                    if (lvl_x >= hi_x)      alarm_nxt = ST_HIGH;
                    else if (lvl_x <= lo_x) alarm_nxt = ST_LOW;
                end
                ST_HIGH:   if (lvl_x + CW'(HYST) < hi_x) alarm_nxt = ST_NORMAL;
                ST_LOW:    if (lvl_x > lo_x + CW'(HYST)) alarm_nxt = ST_NORMAL;
                ST_FAULT:  alarm_nxt = ST_NORMAL;
                default:   alarm_nxt = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            alarm_q <= ST_INIT;
            GOET    <= 1'b0;
            LOET    <= 1'b0;
        end else begin
            alarm_q <= alarm_nxt;
            GOET    <= (alarm_nxt == ST_HIGH);
            LOET    <= (alarm_nxt == ST_LOW);
        end
    end

    assign alarm_state = alarm_q;

endmodule
